// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmit FIFO: drain FSM encoding, bus region
// decode constant and the bit layout of the UART status word.
package uart_tx_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SENT      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_t;

    localparam logic [3:0] UART_REGION = 4'h2;

    localparam int STAT_TX_READY  = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_LEVEL_LSB = 8;
    localparam int STAT_LEVEL_MSB = 12;

    function automatic logic is_uart_addr(input logic [31:0] addr);
        return addr[31:28] == UART_REGION;
    endfunction

    // Assembles the word returned by a status read of the UART region.
    function automatic logic [31:0] pack_status(input logic [4:0] level,
                                                input logic       overflow,
                                                input logic       full,
                                                input logic       empty,
                                                input logic       tx_ready);
        logic [31:0] word;
        word                                = '0;
        word[STAT_LEVEL_MSB:STAT_LEVEL_LSB] = level;
        word[STAT_OVERFLOW]                 = overflow;
        word[STAT_FULL]                     = full;
        word[STAT_EMPTY]                    = empty;
        word[STAT_TX_READY]                 = tx_ready;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy counter; shared by the UART
// transmit path and the future receive path.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both ports; full/empty come from the registered level.
    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; level guards every read, so stale
    // contents are never observed and the array can map to plain flops or RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side byte FIFO for the UART transmitter: buffers bus writes and drains
// them one byte per completed frame through the uart sendReq/ready handshake.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [7:0]             tx_data,
    output logic                   tx_send,
    input  logic                   tx_ready
);

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    tx_state_t      state_q, state_d;
    logic [GW-1:0]  guard_q, guard_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_send_q, tx_send_d;
    logic [7:0]     fifo_rd_data;
    logic           pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .rd_data   (fifo_rd_data),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    // A write that finds the FIFO full is dropped even if a pop frees a slot
    // in the same cycle; the flag is sticky until flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (flush) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end
    end

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        tx_data_d = tx_data_q;
        tx_send_d = 1'b0;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Waiting on tx_ready here also covers a uart still busy with
                // a frame that started before a reset.
                if (!empty && tx_ready && !flush) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rd_data;
                    tx_send_d = 1'b1;
                    state_d   = ST_SENT;
                end
            end
            ST_SENT: begin
                guard_d = GW'(GUARD_CYCLES);
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // The guard stops a uart that accepts without dropping ready
                // from stalling the queue forever.
                if (!tx_ready || guard_q == '0) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    guard_d = guard_q - GW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            guard_q   <= '0;
            tx_data_q <= 8'h00;
            tx_send_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            tx_data_q <= tx_data_d;
            tx_send_q <= tx_send_d;
        end
    end

    assign tx_data = tx_data_q;
    assign tx_send = tx_send_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO between the CPU bus write decode for the UART region (addr[31:28]==4'h2) and the `uart` transmitter.
- Absorbs bursts of CPU byte writes so firmware no longer polls tx_ready per byte.
- Drains automatically into the `uart` sendData/sendReq/ready handshake, one byte per completed transmission.
- Exposes level/full/empty/overflow for a status read word.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- GUARD_CYCLES, 4, max cycles to wait for `uart` ready to fall after a send request before assuming it was accepted.

Ports:
- clk  in  1  system clock (12 MHz)
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  one-cycle write strobe from bus decode
- wr_data  in  8  byte to enqueue
- flush  in  1  synchronous clear of FIFO contents and overflow flag
- level  out  $clog2(DEPTH)+1  number of bytes held, 0..DEPTH
- full  out  1  level==DEPTH
- empty  out  1  level==0
- overflow  out  1  sticky: a write was dropped
- tx_data  out  8  byte to `uart` sendData
- tx_send  out  1  one-cycle send request to `uart` sendReq
- tx_ready  in  1  `uart` idle indication

Behaviour:
- Reset (async assert, sync release by the top-level counter):
  - Pointers = 0, level = 0, empty = 1, full = 0, overflow = 0.
  - tx_send = 0, tx_data = 8'h00, FSM = IDLE.
- Storage: DEPTH x 8 register array; rd_ptr and wr_ptr wrap modulo DEPTH; level is a separate registered counter.
- Write: on wr_en with full==0, store at wr_ptr, then wr_ptr+1.
- Write while full: data dropped, overflow<=1, no pointer change. This holds even if a pop occurs in the same cycle; full is evaluated on the registered level.
- Pop and write in the same cycle with level between 1 and DEPTH-1: level unchanged, both pointers advance.
- flush: pointers and level -> 0, overflow -> 0.
  - A write in the same cycle is discarded.
  - An in-flight transmission is not aborted; the FSM finishes its current wait states.
- Drain FSM:
  - IDLE: if !empty && tx_ready → tx_data<=mem[rd_ptr], rd_ptr+1, level-1, tx_send<=1, go to SENT. Otherwise stay.
  - SENT (tx_send high exactly this one cycle, then 0): guard counter loads GUARD_CYCLES; go to WAIT_BUSY.
  - WAIT_BUSY: if !tx_ready → WAIT_DONE. If the guard counter reaches 0 → WAIT_DONE. Otherwise decrement.
  - WAIT_DONE: if tx_ready → IDLE.
  - Minimum spacing between tx_send pulses is 3 cycles plus the `uart` frame time.
- Latency:
  - Write into an empty FIFO with tx_ready=1 at cycle N: level=1 at N+1; tx_send=1 and tx_data valid at N+2.
  - Status outputs are registered and reflect writes and pops one cycle later.
- tx_data holds its value until the next pop.
- Reset mid-transmission: FSM returns to IDLE. If the `uart` is still busy (tx_ready=0), IDLE waits for tx_ready before any new send, so no byte is corrupted.

Decomposition:
- Shared package: FSM state encoding (IDLE, SENT, WAIT_BUSY, WAIT_DONE), UART region constant 4'h2, and status word bit positions: {level at [12:8], overflow [3], full [2], empty [1], tx_ready [0]}.
- One natural sub-module: sync_fifo (storage, pointers, level, full/empty), reused later for an RX path.
- The drain FSM and overflow flag stay in uart_tx_fifo.

Test Plan:
- Reset then idle with tx_ready=1: empty=1, level=0, tx_send never asserts over 100 cycles.
- Write 8'h41 with tx_ready=1 and a model `uart` dropping ready 1 cycle after sendReq for 1250 cycles:
  - exactly one tx_send pulse with tx_data=8'h41 two cycles after wr_en;
  - level returns to 0.
- Burst of 16 writes 8'h00..8'h0F with tx_ready=0: full=1, level=16. Then a 17th write 8'hFF → overflow=1, level stays 16. Then raise tx_ready → 16 pulses in order 00..0F, 8'hFF never sent.
- Model `uart` that never drops ready: the FSM leaves WAIT_BUSY after GUARD_CYCLES=4 and sends the next byte; no hang.
- Write at level=5 while the FSM pops: level stays 5; byte order preserved across pointer wrap (entries 14,15,0,1).
- flush with level=7 and overflow=1 during an active frame: level=0, overflow=0, current frame completes, no further tx_send. Async resetn pulse mid-frame: tx_send=0 immediately, no send until tx_ready=1.
